// File: rtl/mem_stage.sv
// mem_stage: Beta CPU memory-access slot with req/gnt/rvalid data port, alignment traps and flush
`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h77DF_0000
`endif

module mem_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NOP_INST = `INST_NOP,
    parameter logic [XLEN-1:0] EXC_INST = `INST_BNE_EXCEPT,
    parameter bit ALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] ir_in,
    input  logic [XLEN-1:0] y_in,
    input  logic [XLEN-1:0] d_in,
    input  logic            exc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] ir_out,
    output logic [XLEN-1:0] y_out,
    output logic [XLEN-1:0] rdata_out,
    output logic            exc_out,
    output logic            op_ld_or_ldr,
    output logic            op_st,
    output logic            op_br_or_jmp,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    typedef enum logic [2:0] {EMPTY, ISSUE, WAIT_R, FULL, DRAIN} state_t;
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;

    state_t state;
    logic [5:0] opc;
    logic is_ld, is_st, misaligned, issue, accept;
    logic [XLEN-1:0] ir_next;

    function automatic logic [2:0] decode(input logic [5:0] op);
        return {op == OP_LD || op == OP_LDR, op == OP_ST, op == OP_JMP || op == OP_BEQ || op == OP_BNE};
    endfunction

    assign opc        = ir_in[31:26];
    assign is_ld      = opc == OP_LD || opc == OP_LDR;
    assign is_st      = opc == OP_ST;
    assign misaligned = ALIGN_TRAP && (is_ld || is_st) && y_in[1:0] != 2'b00;
    assign issue      = !exc_in && !misaligned && (is_ld || is_st);
    assign ir_next    = exc_in ? NOP_INST : misaligned ? EXC_INST : ir_in;
    assign in_ready   = !flush && (state == EMPTY || (state == FULL && out_ready));
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            out_valid    <= 1'b0;
            exc_out      <= 1'b0;
            ir_out       <= NOP_INST;
            pc_out       <= '0;
            y_out        <= '0;
            rdata_out    <= '0;
            op_ld_or_ldr <= 1'b0;
            op_st        <= 1'b0;
            op_br_or_jmp <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else if (flush) begin
            // a flushed load already granted must still swallow its response
            out_valid <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state     <= (state == WAIT_R || state == DRAIN) && !mem_rvalid ? DRAIN : EMPTY;
        end else if (accept) begin
            pc_out    <= pc_in;
            y_out     <= y_in;
            ir_out    <= ir_next;
            rdata_out <= '0;
            exc_out   <= exc_in || misaligned;
            {op_ld_or_ldr, op_st, op_br_or_jmp} <= decode(ir_next[31:26]);
            state     <= issue ? ISSUE : FULL;
            out_valid <= !issue;
            mem_req   <= issue;
            mem_we    <= issue && is_st;
            if (issue) begin
                mem_addr  <= {y_in[XLEN-1:2], 2'b00};
                mem_wdata <= d_in;
            end
        end else begin
            case (state)
                ISSUE: if (mem_gnt) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    out_valid <= op_st;
                    state     <= op_st ? FULL : WAIT_R;
                end
                WAIT_R: if (mem_rvalid) begin
                    rdata_out <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= FULL;
                end
                FULL: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
                DRAIN: if (mem_rvalid) state <= EMPTY;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_stage;
    localparam logic [31:0] TB_NOP = 32'h83FF_F800;
    localparam logic [31:0] TB_EXC = 32'h77DF_0000;
    localparam logic [31:0] ADD_I  = 32'h8043_1000;
    localparam logic [31:0] ST_I   = 32'h6422_0000;
    localparam logic [31:0] LD_I   = 32'h6022_0000;

    logic clk, rst_n, in_valid, in_ready, exc_in, flush, out_valid, out_ready, exc_out;
    logic op_ld_or_ldr, op_st, op_br_or_jmp, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] pc_in, ir_in, y_in, d_in, pc_out, ir_out, y_out, rdata_out;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_stage #(.XLEN(32), .NOP_INST(TB_NOP), .EXC_INST(TB_EXC), .ALIGN_TRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .d_in(d_in), .exc_in(exc_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .ir_out(ir_out),
        .y_out(y_out), .rdata_out(rdata_out), .exc_out(exc_out), .op_ld_or_ldr(op_ld_or_ldr),
        .op_st(op_st), .op_br_or_jmp(op_br_or_jmp), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    typedef struct { logic [31:0] pc, ir, y, rd; logic exc, ld, st, br; } exp_t;
    typedef struct { logic we; logic [31:0] addr, wd; } mop_t;

    exp_t exp_q[$];
    mop_t mop_q[$];
    logic [31:0] model_mem [64];
    logic [31:0] resp_mem [64];
    bit rd_pend;
    int rd_dly;
    logic [31:0] rd_data;
    int n_cmp = 0, n_err = 0, n_out = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, ir, y, d, input logic exc);
        in_valid = 1'b1; pc_in = pc; ir_in = ir; y_in = y; d_in = d; exc_in = exc;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] ops [8] = '{6'b011000, 6'b011001, 6'b011111, 6'b011011,
                                6'b011100, 6'b011101, 6'b100000, 6'b000000};
        logic [5:0] o = ops[$urandom_range(0, 7)];
        if (o == 6'b000000) o = 6'($urandom);
        return {o, 26'($urandom)};
    endfunction

    function automatic bit is_mem(input logic [5:0] o);
        return o == 6'b011000 || o == 6'b011001 || o == 6'b011111;
    endfunction

    function automatic exp_t model(input logic [31:0] pc, ir, y, input logic exc);
        exp_t e;
        logic [5:0] o;
        e.pc = pc; e.y = y; e.rd = '0;
        e.exc = exc || (is_mem(ir[31:26]) && y[1:0] != 2'b00);
        e.ir = exc ? TB_NOP : e.exc ? TB_EXC : ir;
        o = e.ir[31:26];
        e.ld = o == 6'b011000 || o == 6'b011111;
        e.st = o == 6'b011001;
        e.br = o == 6'b011011 || o == 6'b011100 || o == 6'b011101;
        return e;
    endfunction

    task automatic rand_cycle(input bit allow_in);
        bit fl;
        exp_t e;
        mop_t m;
        @(negedge clk);
        fl = allow_in && $urandom_range(0, 24) == 0;
        flush = fl;
        out_ready = !fl && $urandom_range(0, 3) != 0;
        in_valid = allow_in && $urandom_range(0, 2) != 0;
        ir_in = rand_ir(); pc_in = $urandom; d_in = $urandom;
        y_in = {24'h0, 6'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00};
        exc_in = $urandom_range(0, 9) == 0;
        mem_gnt = mem_req && !fl && $urandom_range(0, 2) == 0;
        if (rd_pend && rd_dly == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rd_data; rd_pend = 1'b0;
        end else begin
            mem_rvalid = !rd_pend && $urandom_range(0, 15) == 0;
            mem_rdata = $urandom;
            if (rd_pend) rd_dly--;
        end
        #1;
        if (exp_q.size() == 0) check("idle_out_valid", 32'(out_valid), 32'd0);
        if (mop_q.size() == 0) check("idle_mem_req", 32'(mem_req), 32'd0);
        if (fl) check("flush_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_out++;
            check("o_pc", pc_out, e.pc);
            check("o_ir", ir_out, e.ir);
            check("o_y", y_out, e.y);
            check("o_rdata", rdata_out, e.rd);
            check("o_exc", 32'(exc_out), 32'(e.exc));
            check("o_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, {29'b0, e.ld, e.st, e.br});
        end
        if (mem_req && mem_gnt && mop_q.size() != 0) begin
            m = mop_q.pop_front();
            check("m_addr", mem_addr, m.addr);
            check("m_we", 32'(mem_we), 32'(m.we));
            if (m.we) check("m_wdata", mem_wdata, m.wd);
            if (mem_we) resp_mem[mem_addr[7:2]] = mem_wdata;
            else begin
                rd_pend = 1'b1; rd_dly = $urandom_range(0, 3); rd_data = resp_mem[mem_addr[7:2]];
            end
            if (m.we) model_mem[m.addr[7:2]] = m.wd;
            else exp_q[0].rd = model_mem[m.addr[7:2]];
        end
        if (fl) begin
            exp_q.delete();
            mop_q.delete();
        end
        if (in_valid && in_ready) begin
            e = model(pc_in, ir_in, y_in, exc_in);
            exp_q.push_back(e);
            if (!e.exc && is_mem(ir_in[31:26])) begin
                m.we = ir_in[31:26] == 6'b011001; m.addr = y_in; m.wd = d_in;
                mop_q.push_back(m);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; pc_in = '0; ir_in = '0; y_in = '0; d_in = '0; exc_in = 1'b0;
        rd_pend = 1'b0; rd_dly = 0; rd_data = '0;
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = $urandom;
            resp_mem[i] = model_mem[i];
        end
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_exc", 32'(exc_out), 32'd0);
        check("rst_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, 32'd0);
        check("rst_ir", ir_out, TB_NOP);
        check("rst_pc", pc_out, 32'd0);
        check("rst_y", y_out, 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        drive(32'h100, ADD_I, 32'h55, 32'h0, 1'b0);
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_ir", ir_out, ADD_I);
        check("add_y", y_out, 32'h55);
        check("add_pc", pc_out, 32'h100);
        check("add_req", 32'(mem_req), 32'd0);
        drive(32'h104, ADD_I, 32'h66, 32'h0, 1'b0);
        #1 check("b2b_ready", 32'(in_ready), 32'd1);
        @(negedge clk); in_valid = 1'b0;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_pc", pc_out, 32'h104);
        @(negedge clk);
        check("b2b_empty", 32'(out_valid), 32'd0);

        drive(32'h200, ST_I, 32'h40, 32'hDEADBEEF, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            #1;
            check("st_req", 32'(mem_req), 32'd1);
            check("st_addr", mem_addr, 32'h40);
            check("st_wdata", mem_wdata, 32'hDEADBEEF);
            check("st_we", 32'(mem_we), 32'd1);
            check("st_ready", 32'(in_ready), 32'd0);
            check("st_valid_early", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        check("st_valid", 32'(out_valid), 32'd1);
        check("st_req_done", 32'(mem_req), 32'd0);
        check("st_flag", 32'(op_st), 32'd1);
        @(negedge clk);

        drive(32'h300, LD_I, 32'h80, 32'h0, 1'b0);
        @(negedge clk); in_valid = 1'b0; mem_gnt = 1'b1;
        #1;
        check("ld_req", 32'(mem_req), 32'd1);
        check("ld_we", 32'(mem_we), 32'd0);
        check("ld_addr", mem_addr, 32'h80);
        @(negedge clk); mem_gnt = 1'b0;
        check("ld_wait1", 32'(out_valid), 32'd0);
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        check("ld_wait2", 32'(out_valid), 32'd0);
        @(negedge clk); mem_rvalid = 1'b0;
        check("ld_valid", 32'(out_valid), 32'd1);
        check("ld_rdata", rdata_out, 32'h12345678);
        check("ld_flag", 32'(op_ld_or_ldr), 32'd1);
        @(negedge clk);

        drive(32'h400, LD_I, 32'h82, 32'h0, 1'b0);
        @(negedge clk);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_valid", 32'(out_valid), 32'd1);
        check("mis_ir", ir_out, TB_EXC);
        check("mis_exc", 32'(exc_out), 32'd1);
        check("mis_br", 32'(op_br_or_jmp), 32'd1);
        drive(32'h404, ADD_I, 32'h11, 32'h0, 1'b1);
        @(negedge clk); in_valid = 1'b0; exc_in = 1'b0;
        check("exi_ir", ir_out, TB_NOP);
        check("exi_exc", 32'(exc_out), 32'd1);
        @(negedge clk);

        drive(32'h500, LD_I, 32'h10, 32'h0, 1'b0);
        @(negedge clk); in_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; flush = 1'b1;
        #1 check("fl_ready", 32'(in_ready), 32'd0);
        @(negedge clk); flush = 1'b0; drive(32'h504, ADD_I, 32'h1, 32'h0, 1'b0);
        #1;
        check("drain_ready", 32'(in_ready), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
        @(negedge clk); in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
        check("drain_valid2", 32'(out_valid), 32'd0);
        @(negedge clk); mem_rvalid = 1'b0;
        #1;
        check("drain_done_valid", 32'(out_valid), 32'd0);
        check("drain_done_ready", 32'(in_ready), 32'd1);

        drive(32'h600, LD_I, 32'h20, 32'h0, 1'b0);
        @(negedge clk); in_valid = 1'b0; flush = 1'b1;
        check("fi_req", 32'(mem_req), 32'd1);
        @(negedge clk); flush = 1'b0;
        check("fi_req_drop", 32'(mem_req), 32'd0);
        check("fi_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        drive(32'h700, ADD_I, 32'h77, 32'h0, 1'b0);
        @(negedge clk); drive(32'h704, ADD_I, 32'h78, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc", pc_out, 32'h700);
            check("bp_y", y_out, 32'h77);
            check("bp_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk); in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_pc", pc_out, 32'h704);
        @(negedge clk);

        repeat (3000) rand_cycle(1'b1);
        repeat (60) rand_cycle(1'b0);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_progress", 32'(n_out > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
